// File: rtl/jam_pkg.sv
// Shared constants and FSM state encoding for the JAM cost-table server.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jam_pkg;
    localparam int COST_W    = 7;
    localparam int N_SIDE    = 8;
    localparam int IDX_W     = 3;
    localparam int ADDR_W    = 2 * IDX_W;
    localparam int N_ENTRIES = N_SIDE * N_SIDE;
    localparam int MINCOST_W = 10;
    localparam int MATCH_W   = 4;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_ARMED,
        ST_RESET_JAM,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_e;
endpackage

// File: rtl/jam_cost_table.sv
// 64-entry worker/job cost storage with one write port and a registered-address read port.
// Latency: W/J presented in cycle n gives Cost in cycle n+1; a same-cycle write is seen the cycle after.
// Backpressure: none; a new address is accepted every cycle.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COST_W-1:0] wr_dat,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost
);
    logic [COST_W-1:0] mem_q [N_ENTRIES];
    logic [ADDR_W-1:0] addr_d, addr_q;

    // Next read address is always the current worker/job pair.
    always_comb begin
        addr_d = {W, J};
    end

    // Register the read address; storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        addr_q <= addr_d;
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    // Read is combinational from the registered address, so a write to the same
    // entry in this cycle is still showing the old contents.
    assign Cost = mem_q[addr_q];
endmodule

// File: rtl/jam_cost_server.sv
// Cost-table responder and result checker wrapped around a JAM job-assignment core.
// Latency: Cost one cycle after W/J; done/pass/timeout register one cycle after Valid or the last RUN cycle.
// Backpressure: ld_ready is high only while loading; start/reload pulses are ignored outside ARMED/DONE/TIMEOUT.
module jam_cost_server
    import jam_pkg::*;
#(
    parameter int TIMEOUT = 10000000,
    parameter int CNT_W   = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [COST_W-1:0]    ld_data,
    input  logic [MINCOST_W-1:0] gold_min_cost,
    input  logic [MATCH_W-1:0]   gold_match_count,
    input  logic                 start,
    input  logic                 reload,
    output logic                 jam_rst,
    input  logic [IDX_W-1:0]     W,
    input  logic [IDX_W-1:0]     J,
    output logic [COST_W-1:0]    Cost,
    input  logic                 Valid,
    input  logic [MINCOST_W-1:0] MinCost,
    input  logic [MATCH_W-1:0]   MatchCount,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_count
);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_ENTRIES - 1);

    state_e               state_d, state_q;
    logic [ADDR_W-1:0]    idx_d, idx_q;
    logic                 rj_cnt_d, rj_cnt_q;
    logic [CNT_W-1:0]     cycle_count_d, cycle_count_q;
    logic                 done_d, done_q;
    logic                 pass_d, pass_q;
    logic                 timeout_d, timeout_q;
    logic [MINCOST_W-1:0] gold_min_d, gold_min_q;
    logic [MATCH_W-1:0]   gold_match_d, gold_match_q;
    logic                 wr_en;

    jam_cost_table u_table (
        .CLK     (CLK),
        .wr_en   (wr_en),
        .wr_addr (idx_q),
        .wr_dat  (ld_data),
        .W       (W),
        .J       (J),
        .Cost    (Cost)
    );

    // Run sequencing: table load, arm, two-cycle JAM reset, run with timeout, result hold.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rj_cnt_d      = rj_cnt_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        gold_min_d    = gold_min_q;
        gold_match_d  = gold_match_q;
        wr_en         = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (ld_valid) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED, ST_DONE, ST_TIMEOUT: begin
                // start takes priority over reload; results clear as JAM reset begins.
                if (start) begin
                    state_d       = ST_RESET_JAM;
                    gold_min_d    = gold_min_cost;
                    gold_match_d  = gold_match_count;
                    rj_cnt_d      = 1'b0;
                    cycle_count_d = '0;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    timeout_d     = 1'b0;
                end else if (reload) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_RESET_JAM: begin
                rj_cnt_d = 1'b1;
                if (rj_cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cycle_count_q != CNT_LAST) begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
                // A Valid on the final cycle still counts as a result, not a timeout.
                if (Valid) begin
                    done_d  = 1'b1;
                    pass_d  = (MinCost == gold_min_q) && (MatchCount == gold_match_q);
                    state_d = ST_DONE;
                end else if (cycle_count_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = '0;
            end
        endcase
    end

    // Control state registers with synchronous reset; table contents survive reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_LOAD;
            idx_q         <= '0;
            rj_cnt_q      <= 1'b0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            gold_min_q    <= '0;
            gold_match_q  <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rj_cnt_q      <= rj_cnt_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            gold_min_q    <= gold_min_d;
            gold_match_q  <= gold_match_d;
        end
    end

    assign ld_ready    = (state_q == ST_LOAD);
    assign jam_rst     = (state_q != ST_RUN);
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench for jam_cost_server with a small stub JAM driven from the stimulus sequence.
// Latency: inputs change #1 after a rising edge, outputs are checked at the same point.
// Backpressure: the bench only transfers load entries while it expects ld_ready to be high.
module tb_jam_cost_server;
    logic       CLK;
    logic       RST;
    logic       ld_valid;
    logic       ld_ready;
    logic [6:0] ld_data;
    logic [9:0] gold_min_cost;
    logic [3:0] gold_match_count;
    logic       start;
    logic       reload;
    logic       jam_rst;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       Valid;
    logic [9:0] MinCost;
    logic [3:0] MatchCount;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [23:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;
    int model [64];

    jam_cost_server #(.TIMEOUT(100), .CNT_W(24)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .ld_data          (ld_data),
        .gold_min_cost    (gold_min_cost),
        .gold_match_count (gold_match_count),
        .start            (start),
        .reload           (reload),
        .jam_rst          (jam_rst),
        .W                (W),
        .J                (J),
        .Cost             (Cost),
        .Valid            (Valid),
        .MinCost          (MinCost),
        .MatchCount       (MatchCount),
        .done             (done),
        .pass             (pass),
        .timeout          (timeout),
        .cycle_count      (cycle_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int patv(input int which, input int k);
        case (which)
            0:       return k % 100;
            1:       return (k * 13 + 5) % 97;
            default: return 127 - k;
        endcase
    endfunction

    // Load entries [first, first+n) with pattern 'which'; pattern 1 also probes
    // the same-entry write/read case at entry 10.
    task automatic load_entries(input int which, input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            if (which == 1 && k == 9) begin
                W = 3'd1;
                J = 3'd2;
            end
            if (which == 1 && k == 10) chk("rd_same_cycle_old", Cost, model[10]);
            if (which == 1 && k == 11) chk("rd_after_write_new", Cost, patv(1, 10));
            ld_valid = 1'b1;
            ld_data  = 7'(patv(which, k));
            model[k] = patv(which, k);
            step();
        end
        ld_valid = 1'b0;
    endtask

    // Accept start and measure how long jam_rst stays high before RUN.
    task automatic start_run(input int gmin, input int gmatch);
        int n;
        gold_min_cost    = 10'(gmin);
        gold_match_count = 4'(gmatch);
        start = 1'b1;
        step();
        start = 1'b0;
        gold_min_cost    = 10'd0;
        gold_match_count = 4'd0;
        chk("start_clears_done", done, 0);
        chk("start_clears_timeout", timeout, 0);
        n = 0;
        while (jam_rst === 1'b1 && n < 10) begin
            n++;
            step();
        end
        chk("jam_rst_cycles", n, 2);
    endtask

    // Stub JAM: sums the diagonal assignment through the Cost port.
    task automatic run_diag(input logic noisy, output int sum);
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            W = 3'(i);
            J = 3'(i);
            if (noisy) begin
                ld_valid = 1'b1;
                ld_data  = 7'(i * 17 + 3);
            end
            step();
            if (noisy && i == 4) chk("ld_ready_in_run", ld_ready, 0);
            sum += int'(Cost);
        end
        ld_valid = 1'b0;
    endtask

    task automatic give_result(input int mc, input int cnt);
        Valid      = 1'b1;
        MinCost    = 10'(mc);
        MatchCount = 4'(cnt);
        step();
        Valid      = 1'b0;
    endtask

    initial begin
        int gold;
        int sum;
        int n;
        RST = 1'b1; ld_valid = 1'b0; ld_data = '0; gold_min_cost = '0; gold_match_count = '0;
        start = 1'b0; reload = 1'b0; W = '0; J = '0; Valid = 1'b0; MinCost = '0; MatchCount = '0;
        for (int k = 0; k < 64; k++) model[k] = 0;
        step();
        step();
        RST = 1'b0;

        // Reset state.
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_jam_rst", jam_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycle_count", cycle_count, 0);

        // Test 1: k%100 table and basic reads, start ignored during load.
        start = 1'b1;
        load_entries(0, 0, 63);
        chk("ld_ready_before_last", ld_ready, 1);
        load_entries(0, 63, 1);
        start = 1'b0;
        chk("ld_ready_armed", ld_ready, 0);
        chk("armed_jam_rst", jam_rst, 1);
        W = 3'd3; J = 3'd5; step();
        chk("cost_3_5", Cost, 29);
        W = 3'd7; J = 3'd7; step();
        chk("cost_7_7", Cost, 63);
        W = 3'd0; J = 3'd0; step();
        chk("cost_0_0", Cost, 0);

        // Test 2: reload with pattern 1, full run with stub JAM.
        reload = 1'b1; step(); reload = 1'b0;
        chk("reload_ld_ready", ld_ready, 1);
        load_entries(1, 0, 64);
        chk("ld_ready_armed2", ld_ready, 0);
        gold = 0;
        for (int i = 0; i < 8; i++) gold += patv(1, i * 9);
        start_run(gold, 1);
        run_diag(1'b0, sum);
        chk("diag_sum", sum, gold);
        give_result(sum, 1);
        chk("run_done", done, 1);
        chk("run_pass", pass, 1);
        chk("run_timeout", timeout, 0);
        chk("run_jam_rst", jam_rst, 1);
        chk("run_cycles", cycle_count, 9);
        give_result(0, 0);
        chk("done_ignores_valid", pass, 1);

        // Test 6: rerun from DONE while load port is driven -> identical result.
        start_run(gold, 1);
        run_diag(1'b1, sum);
        chk("rerun_diag_sum", sum, gold);
        give_result(sum, 1);
        chk("rerun_done", done, 1);
        chk("rerun_pass", pass, 1);
        chk("rerun_cycles", cycle_count, 9);

        // Test 3: wrong MinCost, then wrong MatchCount.
        start_run(299, 2);
        give_result(300, 2);
        chk("bad_min_done", done, 1);
        chk("bad_min_pass", pass, 0);
        chk("bad_min_timeout", timeout, 0);
        chk("bad_min_cycles", cycle_count, 1);
        start_run(299, 2);
        give_result(299, 3);
        chk("bad_cnt_pass", pass, 0);
        start_run(299, 2);
        give_result(299, 2);
        chk("good_pass", pass, 1);

        // Valid on the last allowed cycle wins over timeout.
        start_run(5, 1);
        for (int i = 0; i < 99; i++) step();
        chk("edge_no_timeout_yet", timeout, 0);
        give_result(5, 1);
        chk("edge_done", done, 1);
        chk("edge_timeout", timeout, 0);
        chk("edge_cycles", cycle_count, 99);

        // Test 4: no Valid -> timeout after exactly 100 RUN cycles.
        start_run(5, 1);
        n = 0;
        while (timeout !== 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("timeout_run_cycles", n, 100);
        chk("timeout_count", cycle_count, 99);
        chk("timeout_jam_rst", jam_rst, 1);
        chk("timeout_done", done, 0);
        give_result(5, 1);
        step();
        chk("timeout_ignores_valid", done, 0);
        chk("timeout_count_frozen", cycle_count, 99);

        // Test 5: RST after 30 transfers; 64 further transfers required.
        reload = 1'b1; step(); reload = 1'b0;
        chk("reload_from_timeout", ld_ready, 1);
        load_entries(0, 0, 30);
        RST = 1'b1; step(); RST = 1'b0;
        chk("midload_rst_ld_ready", ld_ready, 1);
        chk("midload_rst_timeout", timeout, 0);
        chk("midload_rst_count", cycle_count, 0);
        load_entries(2, 0, 63);
        chk("midload_not_armed", ld_ready, 1);
        load_entries(2, 63, 1);
        chk("midload_armed", ld_ready, 0);
        W = 3'd0; J = 3'd0; step();
        chk("reload_cost_0", Cost, 127);
        W = 3'd4; J = 3'd6; step();
        chk("reload_cost_38", Cost, 127 - 38);

        // start and reload together: start wins.
        start = 1'b1; reload = 1'b1; step(); start = 1'b0; reload = 1'b0;
        chk("start_wins_ld_ready", ld_ready, 0);
        step(); step();
        chk("start_wins_run", jam_rst, 0);
        give_result(0, 0);
        chk("start_wins_done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
